// File: rtl/trail_compositor.sv
// Packed trail frame buffer with bike sprite overlay, per-player crash
// detection and a hardware clear sequencer; 2-cycle scan-out pipeline.
module trail_compositor #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int PIX_BITS    = 4,
  parameter int WORD_BITS   = 16,
  parameter int NUM_PLAYERS = 2,
  parameter int BG_ENUM     = 0,
  parameter int TRAIL_BASE  = 4,
  localparam int PPW    = WORD_BITS / PIX_BITS,
  localparam int DEPTH  = H_RES * V_RES / PPW,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            frame_clk,
  input  logic                            WE,
  input  logic [ADDR_W-1:0]               write_address,
  input  logic [WORD_BITS-1:0]            Data_In,
  input  logic [9:0]                      DrawX,
  input  logic [9:0]                      DrawY,
  input  logic [NUM_PLAYERS*PIX_BITS-1:0] Bike_Enum,
  input  logic                            Clear_Start,
  output logic                            Clear_Busy,
  output logic [PIX_BITS-1:0]             color_enum,
  output logic [NUM_PLAYERS-1:0]          Crash
);

  localparam int SLOT_W = $clog2(PPW);
  localparam int IDX_W  = ADDR_W + SLOT_W;
  localparam int SPR_W  = NUM_PLAYERS * PIX_BITS;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  localparam logic [PIX_BITS-1:0] BG     = PIX_BITS'(BG_ENUM);
  localparam logic [PIX_BITS-1:0] TRANSP = {PIX_BITS{1'b1}};
  localparam logic [ADDR_W-1:0]   LAST   = ADDR_W'(DEPTH - 1);

  logic [WORD_BITS-1:0] mem [DEPTH];
  logic [WORD_BITS-1:0] q;

  logic [0:0]           state;
  logic [ADDR_W-1:0]    cnt;
  logic                 we;
  logic [ADDR_W-1:0]    wa;
  logic [ADDR_W-1:0]    ra;
  logic [WORD_BITS-1:0] wd;

  logic                 v0;
  logic [9:0]           x0;
  logic [9:0]           y0;
  logic [SPR_W-1:0]     spr0;
  logic                 act0;
  logic [IDX_W-1:0]     idx;

  logic                 act1;
  logic [SLOT_W-1:0]    slot1;
  logic [SPR_W-1:0]     spr1;

  logic [PIX_BITS-1:0]    trail;
  logic [PIX_BITS-1:0]    pix;
  logic [NUM_PLAYERS-1:0] opq;
  logic [NUM_PLAYERS-1:0] hits;
  logic [NUM_PLAYERS-1:0] pending;
  logic                   fc_d;

  assign Clear_Busy = (state == S_CLEAR);

  // The sequencer owns the write port for the whole clear.
  always_comb begin
    we = Clear_Busy | (WE & (write_address <= LAST));
    wa = Clear_Busy ? cnt : write_address;
    wd = Clear_Busy ? {PPW{BG}} : Data_In;
  end

  always_ff @(posedge Clk) begin
    if (we)
      mem[wa] <= wd;
    q <= mem[ra];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Clear_Start) begin
            state <= S_CLEAR;
            cnt   <= '0;
          end
        end
        S_CLEAR: begin
          if (cnt == LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // v0 keeps the cleared stage-0 registers from looking like a live pixel.
  always_comb begin
    act0 = v0 && (x0 < 10'(H_RES)) && (y0 < 10'(V_RES));
    idx  = IDX_W'(y0) * IDX_W'(H_RES) + IDX_W'(x0);
    ra   = act0 ? idx[IDX_W-1:SLOT_W] : '0;
  end

  always_comb begin
    trail = q[PIX_BITS*int'(slot1) +: PIX_BITS];
    opq   = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      opq[p] = spr1[p*PIX_BITS +: PIX_BITS] != TRANSP;
    pix = trail;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--)
      if (opq[p])
        pix = spr1[p*PIX_BITS +: PIX_BITS];
    hits = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      hits[p] = act1 & opq[p] &
        (((trail != BG) && (trail != PIX_BITS'(TRAIL_BASE + p))) |
         (|(opq & ~(NUM_PLAYERS'(1) << p))));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v0         <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      spr0       <= '0;
      act1       <= 1'b0;
      slot1      <= '0;
      spr1       <= '0;
      color_enum <= BG;
      pending    <= '0;
      Crash      <= '0;
      fc_d       <= 1'b0;
    end else begin
      v0         <= 1'b1;
      x0         <= DrawX;
      y0         <= DrawY;
      spr0       <= Bike_Enum;
      act1       <= act0;
      slot1      <= idx[SLOT_W-1:0];
      spr1       <= spr0;
      color_enum <= act1 ? pix : BG;
      fc_d       <= frame_clk;
      if (frame_clk & ~fc_d) begin
        Crash   <= pending | hits;
        pending <= '0;
      end else begin
        pending <= pending | hits;
      end
    end
  end

endmodule

// File: tb/tb_trail_compositor.sv
// Randomised and directed bench for trail_compositor against a
// frame-buffer/compositing model of the scan-out and crash rules.
module tb_trail_compositor;

  localparam int H     = 160;
  localparam int V     = 64;
  localparam int PPW   = 4;
  localparam int DEPTH = H * V / PPW;
  localparam int AW    = $clog2(DEPTH);
  localparam int NP    = 2;
  localparam int TB    = 4;
  localparam logic [3:0] BG4 = 4'h0;

  typedef struct packed {
    logic [3:0] color;
    logic [1:0] hits;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_clk = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [15:0]   din = '0;
  logic [9:0]    dx = 10'd700;
  logic [9:0]    dy = 10'd0;
  logic [7:0]    bike = 8'hFF;
  logic          cs = 1'b0;
  logic          busy;
  logic [3:0]    color;
  logic [1:0]    crash;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  logic [15:0] mem_m [DEPTH];
  res_t        pipe_q [$];
  logic [1:0]  pending_m;
  logic [1:0]  exp_crash;
  logic [3:0]  exp_color;
  logic        exp_busy;
  int          clr_left;
  int          clr_ptr;
  logic        fc_prev;

  trail_compositor #(.H_RES(H), .V_RES(V)) dut (
    .Clk          (clk),
    .Reset        (rst),
    .frame_clk    (frame_clk),
    .WE           (we),
    .write_address(waddr),
    .Data_In      (din),
    .DrawX        (dx),
    .DrawY        (dy),
    .Bike_Enum    (bike),
    .Clear_Start  (cs),
    .Clear_Busy   (busy),
    .color_enum   (color),
    .Crash        (crash)
  );

  initial forever #5 clk = ~clk;

  function automatic res_t model_pix(int x, int y, logic [7:0] b);
    res_t r;
    int i, w, k, win, nop;
    logic [3:0] tr, s;
    logic [1:0] op;
    r.color = BG4;
    r.hits = '0;
    if (x >= H || y >= V) return r;
    i = y * H + x;
    w = i / PPW;
    k = i % PPW;
    tr = mem_m[w][k*4 +: 4];
    win = -1;
    nop = 0;
    op = '0;
    for (int p = 0; p < NP; p++) begin
      s = b[p*4 +: 4];
      if (s != 4'hF) begin
        op[p] = 1'b1;
        nop++;
        if (win < 0) win = p;
      end
    end
    r.color = (win >= 0) ? b[win*4 +: 4] : tr;
    for (int p = 0; p < NP; p++)
      r.hits[p] = op[p] && ((tr != BG4 && int'(tr) != TB + p) || nop > 1);
    return r;
  endfunction

  task automatic m_reset();
    res_t idle;
    idle.color = BG4;
    idle.hits = '0;
    pipe_q.delete();
    pipe_q.push_back(idle);
    pipe_q.push_back(idle);
    pending_m = '0;
    exp_crash = '0;
    exp_color = BG4;
    exp_busy = 1'b0;
    clr_left = 0;
    clr_ptr = 0;
    fc_prev = 1'b0;
  endtask

  task automatic m_step();
    res_t r, o;
    if (clr_left > 0) begin
      mem_m[clr_ptr] = {PPW{BG4}};
      clr_ptr++;
      clr_left--;
    end else begin
      if (we && int'(waddr) < DEPTH) mem_m[waddr] = din;
      if (cs) begin
        clr_left = DEPTH;
        clr_ptr = 0;
      end
    end
    r = model_pix(int'(dx), int'(dy), bike);
    pipe_q.push_back(r);
    o = pipe_q.pop_front();
    if (frame_clk && !fc_prev) begin
      exp_crash = pending_m | o.hits;
      pending_m = '0;
    end else begin
      pending_m = pending_m | o.hits;
    end
    fc_prev = frame_clk;
    exp_color = o.color;
    exp_busy = clr_left > 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      checks++;
      if (color !== exp_color) begin
        errors++;
        $display("FAIL color_enum got %0h want %0h t=%0t", color, exp_color, $time);
      end
      checks++;
      if (crash !== exp_crash) begin
        errors++;
        $display("FAIL crash got %0b want %0b t=%0t", crash, exp_crash, $time);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL clear_busy got %0b want %0b t=%0t", busy, exp_busy, $time);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(int x, int y, logic [7:0] b);
    dx = 10'(x);
    dy = 10'(y);
    bike = b;
    step();
  endtask

  task automatic wr(int a, logic [15:0] d);
    we = 1'b1;
    waddr = AW'(a);
    din = d;
    step();
    we = 1'b0;
  endtask

  task automatic frame_edge();
    frame_clk = 1'b1;
    step();
  endtask

  int n;
  int nz;
  int r;

  initial begin
    repeat (3) step();
    started = 1;
    rst = 1'b0;
    repeat (2) step();
    chk("reset_color", int'(color), 0);
    chk("reset_crash", int'(crash), 0);

    for (int w = 0; w < 64; w++) wr(w, 16'($urandom));
    wr(0, 16'h4321);
    wr(5, 16'h0000);
    wr(2025, 16'h0005);
    wr(2026, 16'h0005);

    pix(0, 0, 8'hFF);
    pix(1, 0, 8'hFF);
    pix(2, 0, 8'hFF);
    chk("unpack_0", int'(color), 1);
    pix(3, 0, 8'hFF);
    chk("unpack_1", int'(color), 2);
    pix(700, 0, 8'hFF);
    chk("unpack_2", int'(color), 3);
    step();
    chk("unpack_3", int'(color), 4);
    step();
    chk("inactive_x700", int'(color), 0);

    pix(100, 50, 8'hF2);
    pix(104, 50, 8'h3F);
    pix(700, 0, 8'hFF);
    chk("crash_pix_color", int'(color), 2);
    step();
    chk("own_trail_color", int'(color), 3);
    frame_edge();
    chk("crash_p0", int'(crash), 1);
    frame_clk = 1'b0;
    step();

    pix(20, 0, 8'h32);
    pix(700, 0, 8'hFF);
    step();
    chk("headon_color", int'(color), 2);
    frame_edge();
    chk("headon_crash", int'(crash), 3);
    frame_clk = 1'b0;
    repeat (4) step();
    frame_edge();
    chk("quiet_frame", int'(crash), 0);
    frame_clk = 1'b0;
    step();

    pix(100, 50, 8'hF2);
    pix(700, 0, 8'hFF);
    frame_edge();
    chk("hit_on_edge", int'(crash), 1);
    frame_clk = 1'b0;
    repeat (3) step();
    frame_edge();
    chk("hit_on_edge_not_pending", int'(crash), 0);
    frame_clk = 1'b0;
    step();

    pix(20, 0, 8'h32);
    pix(700, 0, 8'hFF);
    step();
    frame_edge();
    chk("headon_again", int'(crash), 3);
    frame_clk = 1'b0;
    pix(20, 0, 8'h32);
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_reset_color", int'(color), 0);
    chk("async_reset_crash", int'(crash), 0);
    chk("async_reset_busy", int'(busy), 0);
    dx = 10'd700;
    bike = 8'hFF;
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();
    chk("post_reset_color", int'(color), 0);
    chk("post_reset_crash", int'(crash), 0);

    for (int c = 0; c < 3000; c++) begin
      we = ($urandom % 4) == 0;
      if ($urandom % 50 == 0) waddr = AW'(DEPTH + $urandom % (2**AW - DEPTH));
      else waddr = AW'($urandom % 64);
      din = 16'($urandom);
      r = $urandom % 8;
      if (r == 0) begin
        dx = 10'(H + $urandom % 300);
        dy = 10'($urandom % 1024);
      end else if (r == 1) begin
        dx = 10'($urandom % H);
        dy = 10'(V + $urandom % 200);
      end else begin
        n = $urandom % 256;
        dx = 10'(n % H);
        dy = 10'(n / H);
      end
      for (int p = 0; p < NP; p++)
        bike[p*4 +: 4] = ($urandom % 3 == 0) ? 4'($urandom % 15) : 4'hF;
      if ($urandom % 8 == 0) frame_clk = ~frame_clk;
      step();
    end
    we = 1'b0;
    frame_clk = 1'b0;
    dx = 10'd700;
    bike = 8'hFF;
    step();

    we = 1'b1;
    din = 16'hFFFF;
    for (int w = 0; w < DEPTH; w++) begin
      waddr = AW'(w);
      step();
    end
    we = 1'b0;

    cs = 1'b1;
    step();
    cs = 1'b0;
    chk("busy_rise", int'(busy), 1);
    n = 0;
    we = 1'b1;
    while (busy && n < DEPTH + 20) begin
      n++;
      waddr = AW'($urandom % DEPTH);
      din = 16'h1234;
      cs = (n == 100);
      step();
    end
    we = 1'b0;
    cs = 1'b0;
    chk("clear_len", n, DEPTH);

    nz = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        pix(x, y, 8'hFF);
        if (color != 4'h0) nz++;
      end
    dx = 10'd700;
    repeat (2) begin
      step();
      if (color != 4'h0) nz++;
    end
    chk("clear_readback_nz", nz, 0);

    for (int w = 990; w <= 1010; w++) wr(w, 16'hFFFF);
    cs = 1'b1;
    step();
    cs = 1'b0;
    repeat (1000) step();
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    step();
    rst = 1'b0;
    step();
    pix(156, 24, 8'hFF);
    pix(0, 25, 8'hFF);
    pix(700, 0, 8'hFF);
    chk("abort_word999", int'(color), 0);
    step();
    chk("abort_word1000", int'(color), 15);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trail_compositor.md
# trail_compositor

Parametrised successor to the two-player frame-buffer/bike combiner. It holds the packed trail frame buffer, overlays NUM_PLAYERS bike sprites on the scan-out stream through a fixed 2-cycle pipeline, and detects per-player crashes, reporting them once per frame. It also has a hardware clear sequencer for round resets. It sits between the game-logic trail writer and the VGA color mapper.

## Interface
- H_RES, 640, active pixels per line
- V_RES, 480, active lines
- PIX_BITS, 4, bits per pixel enum; all-ones enum = transparent sprite pixel
- WORD_BITS, 16, RAM word width; PPW = WORD_BITS/PIX_BITS, must be a power of two dividing H_RES
- NUM_PLAYERS, 2, number of bike sprites/crash flags
- BG_ENUM, 0, background enum
- TRAIL_BASE, 4, player p's own trail enum = TRAIL_BASE+p
- ADDR_W, derived: clog2(H_RES*V_RES/PPW), 17 at defaults

Ports:
- Clk  in  1  system clock; the single clock domain
- Reset  in  1  asynchronous, active-high
- frame_clk  in  1  frame strobe (Clk domain); rising edge = frame boundary
- WE  in  1  trail write enable
- write_address  in  ADDR_W  word address
- Data_In  in  WORD_BITS  full-word write data
- DrawX, DrawY  in  10 each  scan position
- Bike_Enum  in  NUM_PLAYERS*PIX_BITS  sprite pixel per player at (DrawX,DrawY); player p at [p*PIX_BITS +: PIX_BITS]
- Clear_Start  in  1  one-cycle pulse starting a buffer clear
- Clear_Busy  out  1  clear in progress
- color_enum  out  PIX_BITS  composited pixel
- Crash  out  NUM_PLAYERS  per-player crash flags for the previous frame

## Operation
- Pixel index i = DrawY*H_RES + DrawX. Word = i/PPW, slot k = i mod PPW. The pixel occupies word bits [k*PIX_BITS +: PIX_BITS].
- RAM: simple dual port, depth H_RES*V_RES/PPW, 1-cycle synchronous read. On read-during-write to the same address, the read returns the old data. Contents are not reset.
- Compositing: the lowest-index opaque sprite wins. If no sprite is opaque, output the trail pixel. Outside the active region (DrawX≥H_RES or DrawY≥V_RES), output BG_ENUM with no collision evaluation.
- Collision for player p requires p to be opaque at an active pixel, plus either of:
  - the underlying trail pixel is neither BG_ENUM nor TRAIL_BASE+p, or
  - any other player is also opaque at that pixel.
- Hits OR into an internal pending[] register.
- On a frame_clk rising edge (edge detected with one register), set Crash <= pending | hits in the same cycle, then clear pending. Crash holds until the next edge.
- Clear sequencer states:
  - IDLE → CLEAR on Clear_Start.
  - CLEAR: write a word of BG_ENUM replicated to address cnt, cnt increments from 0.
  - After writing the last address, go to IDLE on the next cycle.
- While in CLEAR, WE is ignored and Clear_Start is ignored. Scan-out continues and may read partially cleared data.
- Reset: color_enum=BG_ENUM, Crash=0, pending=0, Clear_Busy=0, state IDLE, cnt=0, pipeline registers cleared. Reset during CLEAR aborts it and leaves the RAM partially cleared.

## Timing
- Stage 0: register DrawX, DrawY and Bike_Enum; compute the address; issue the RAM read.
- Stage 1: RAM data valid; delay the slot index, active flag and sprites.
- Stage 2: register color_enum and hits. Output for inputs sampled at edge t appears after edge t+2.
- Collision hits are registered at stage 2, so a hit sampled at t is applied to pending at t+2. A hit registered in the frame_clk edge cycle goes into Crash.
- A write at edge t is visible to a read issued at t+1 or later.
- Clear_Busy rises the cycle after Clear_Start is sampled. It stays high for exactly depth cycles (76800 at defaults), then falls.

## Test plan
- Reset test: assert Reset mid-scan → color_enum=0, Crash=00 and Clear_Busy=0 immediately. All remain so until stimulus.
- Unpacking test: write word 0 = 16'h4321. Scan DrawY=0, DrawX=0..3 with sprites 4'hF → color_enum 1,2,3,4 on consecutive cycles, starting 2 cycles later. DrawX=700 → 0.
- Crash test: pixel (100,50) holds enum 5 (player 1 trail). Player 0 opaque there (enum 2), player 1 opaque over its own enum-5 pixel elsewhere → color_enum=2 at that pixel. After the next frame_clk edge, Crash=01.
- Head-on test: both players opaque at the same BG pixel (enums 2 and 3) → color_enum=2, Crash=11 after the frame edge. The next frame has no hits → Crash=00.
- Clear test: fill the buffer with 16'hFFFF, pulse Clear_Start, and hold WE=1 with other data during the clear → Clear_Busy high for 76800 cycles. Afterwards every word reads 16'h0000.
- Abort/simultaneity test: assert Reset at clear cycle 1000 → Clear_Busy=0 at once, words ≥1000 unchanged. Separately, a hit coinciding with a frame_clk edge → that player's Crash bit is set.
